// File: rtl/adder_pkg.sv
// adder_pkg: shared slice width and sequencer state encoding for the nibble serial adder
package adder_pkg;
    localparam int SLICE_W = 4;
    typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;
endpackage

// File: rtl/adder_slice4.sv
// adder_slice4: combinational 4-bit ripple-carry slice built from full-adder cells
//   a, b : slice operands    cin : carry into bit 0
//   s    : slice sum         cout : carry out of bit 3
module adder_slice4
    import adder_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] s,
    output logic               cout
);
    logic [SLICE_W:0] c;
    assign c[0] = cin;
    assign cout = c[SLICE_W];
    for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: multi-cycle add/subtract, one 4-bit slice per cycle, LS nibble first
//   clk, reset          : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake (a, b, cin, sub sampled on accept)
//   out_valid/out_ready : result handshake; sum = {carry-out, WIDTH-bit result}
//   busy                : operation in RUN or DONE
module nibble_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             busy
);
    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int CW = NSLICE > 1 ? $clog2(NSLICE) : 1;
    if (WIDTH < SLICE_W || WIDTH % SLICE_W != 0) begin : g_width_chk
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
    end
    seq_state_t       state;
    logic [WIDTH-1:0] a_sh, b_sh, res, res_n;
    logic [CW-1:0]    cnt;
    logic             carry, co;
    logic [SLICE_W-1:0] s;
    adder_slice4 u_slice (
        .a    (a_sh[SLICE_W-1:0]),
        .b    (b_sh[SLICE_W-1:0]),
        .cin  (carry),
        .s    (s),
        .cout (co)
    );
    // Current slice result merged into its nibble position so the final cycle can publish it directly
    always_comb begin
        res_n = res;
        res_n[cnt*SLICE_W +: SLICE_W] = s;
    end
    assign in_ready = state == IDLE && !reset;
    assign busy     = state != IDLE;
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            sum       <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            res       <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_sh  <= a;
                    // Subtraction as a + ~b + 1, with borrow-in removing the +1
                    b_sh  <= sub ? ~b : b;
                    carry <= cin ^ sub;
                    cnt   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    a_sh  <= a_sh >> SLICE_W;
                    b_sh  <= b_sh >> SLICE_W;
                    carry <= co;
                    res   <= res_n;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(NSLICE - 1)) begin
                        sum       <= {co, res_n};
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
